// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler: output FSM encoding
// and the width of the bit counter.
package serial_word_assembler_pkg;

    // Output holding register state: EMPTY has no word, FULL holds an unconsumed word.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Bit counter width: log2(width)+1, enough to count 0..width-1 for any legal width.
    function automatic int bitcount_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_word_assembler_shift_counter.sv
// Shift register plus bit counter. Accepts one bit per qualified cycle and
// reports completion combinationally in the cycle the last bit is accepted,
// together with the completed word, so the consumer can register it on the
// same edge the counter wraps.
module shift_counter
    import serial_word_assembler_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              din,
    input  logic                              din_valid,
    output logic [WIDTH-1:0]                  word,
    output logic                              done,
    output logic [bitcount_width(WIDTH)-1:0]  bit_count
);

    localparam int CW = bitcount_width(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;

    // Next shift register value with the current bit inserted in the configured order.
    always_comb begin
        shifted = shreg;
        if (MSB_FIRST != 0) begin
            shifted = {shreg[WIDTH-2:0], din};
        end else begin
            shifted = {din, shreg[WIDTH-1:1]};
        end
    end

    // Completion is the cycle the WIDTH-th bit is accepted; clear suppresses it.
    assign done = din_valid && !clr && (bit_count == CW'(WIDTH - 1));
    assign word = shifted;

    // Shift and count accepted bits; wrap to an empty register on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (clr) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (din_valid) begin
            if (done) begin
                shreg     <= '0;
                bit_count <= '0;
            end else begin
                shreg     <= shifted;
                bit_count <= bit_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with a one-word output holding register
// and a sticky overflow flag for words dropped while the output is occupied.
//
// Handshake: DoutValid=1 means Dout holds a word not yet consumed; a word is
// consumed on a rising edge where DoutValid=1 and DoutReady=1. While
// DoutValid=1 and DoutReady=0, Dout and DoutValid hold. DoutReady has no
// effect while DoutValid=0. There is no back-pressure on the serial side: a
// word completing while the held word is not being consumed is dropped and
// Overflow is set.
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              Clr,
    input  logic                              Din,
    input  logic                              DinValid,
    output logic [WIDTH-1:0]                  Dout,
    output logic                              DoutValid,
    input  logic                              DoutReady,
    output logic                              Overflow,
    output logic [bitcount_width(WIDTH)-1:0]  BitCount,
    output out_state_e                        dbg_state
);

    logic [WIDTH-1:0] word;
    logic             done;
    out_state_e       state;

    shift_counter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_counter (
        .clk       (CLK),
        .rst_n     (RST),
        .clr       (Clr),
        .din       (Din),
        .din_valid (DinValid),
        .word      (word),
        .done      (done),
        .bit_count (BitCount)
    );

    // Output FSM: holding register, valid flag and sticky overflow, all registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= EMPTY;
            Dout      <= '0;
            DoutValid <= 1'b0;
            Overflow  <= 1'b0;
        end else if (Clr) begin
            state     <= EMPTY;
            DoutValid <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (done) begin
                        state     <= FULL;
                        Dout      <= word;
                        DoutValid <= 1'b1;
                    end
                end
                FULL: begin
                    if (done) begin
                        // Replace only if the held word leaves this edge; else drop the new one.
                        if (DoutReady) begin
                            Dout <= word;
                        end else begin
                            Overflow <= 1'b1;
                        end
                    end else if (DoutReady) begin
                        state     <= EMPTY;
                        DoutValid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    DoutValid <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler at WIDTH=8. Two instances share
// all inputs: one MSB-first, one LSB-first.
module tb_serial_word_assembler;
    import serial_word_assembler_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       din;
    logic       din_valid;
    logic       dout_ready;

    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_ovf;
    logic [3:0] m_cnt;
    out_state_e m_state;

    logic [7:0] l_dout;
    logic       l_valid;
    logic       l_ovf;
    logic [3:0] l_cnt;
    out_state_e l_state;

    int n_cmp;
    int n_err;

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .CLK       (clk),
        .RST       (rst_n),
        .Clr       (clr),
        .Din       (din),
        .DinValid  (din_valid),
        .Dout      (m_dout),
        .DoutValid (m_valid),
        .DoutReady (dout_ready),
        .Overflow  (m_ovf),
        .BitCount  (m_cnt),
        .dbg_state (m_state)
    );

    serial_word_assembler #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .CLK       (clk),
        .RST       (rst_n),
        .Clr       (clr),
        .Din       (din),
        .DinValid  (din_valid),
        .Dout      (l_dout),
        .DoutValid (l_valid),
        .DoutReady (dout_ready),
        .Overflow  (l_ovf),
        .BitCount  (l_cnt),
        .dbg_state (l_state)
    );

    // Drive eight bits, first bit w[7], one per cycle, DinValid held high.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            din       = w[i];
            din_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        #12;
        n_cmp++; if (m_dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", m_dout); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", m_ovf); end
        n_cmp++; if (m_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", m_cnt); end
        n_cmp++; if (m_state !== EMPTY) begin n_err++; $display("FAIL reset_state: got %0d want EMPTY", m_state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_msb_lsb_first();
        logic [7:0] stream;
        stream     = 8'b1011_0010;
        dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            n_cmp++;
            if (m_cnt !== 4'(7 - i)) begin
                n_err++; $display("FAIL bitcount_step%0d: got %0d want %0d", 7 - i, m_cnt, 7 - i);
            end
            din       = stream[i];
            din_valid = 1'b1;
        end
        @(negedge clk);
        din_valid = 1'b0;
        n_cmp++; if (m_dout !== 8'hB2) begin n_err++; $display("FAIL msb_first_dout: got %h want b2", m_dout); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL msb_first_valid: got %b want 1", m_valid); end
        n_cmp++; if (m_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_cnt: got %0d want 0", m_cnt); end
        n_cmp++; if (l_dout !== 8'h4D) begin n_err++; $display("FAIL lsb_first_dout: got %h want 4d", l_dout); end
        n_cmp++; if (l_valid !== 1'b1) begin n_err++; $display("FAIL lsb_first_valid: got %b want 1", l_valid); end
        @(negedge clk);
        dout_ready = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL consume_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_dout !== 8'hB2) begin n_err++; $display("FAIL consume_hold_dout: got %h want b2", m_dout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] second;
        second     = 8'h3C;
        dout_ready = 1'b0;
        send_word(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            n_cmp++;
            if (m_valid !== 1'b1 || m_dout !== 8'hA5) begin
                n_err++; $display("FAIL b2b_hold_bit%0d: got valid=%b dout=%h want valid=1 dout=a5", 7 - i, m_valid, m_dout);
            end
            din        = second[i];
            din_valid  = 1'b1;
            dout_ready = (i == 0);
        end
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        n_cmp++; if (m_dout !== 8'h3C) begin n_err++; $display("FAIL b2b_dout: got %h want 3c", m_dout); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", m_valid); end
        n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", m_ovf); end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_overflow_clr();
        logic [7:0] part;
        part       = 8'b1110_0000;
        dout_ready = 1'b0;
        send_word(8'hA5);
        @(negedge clk);
        din_valid = 1'b0;
        n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before: got %b want 0", m_ovf); end
        send_word(8'hFF);
        @(negedge clk);
        din_valid = 1'b0;
        n_cmp++; if (m_dout !== 8'hA5) begin n_err++; $display("FAIL ovf_dout: got %h want a5", m_dout); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", m_valid); end
        n_cmp++; if (m_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", m_ovf); end
        repeat (3) @(negedge clk);
        n_cmp++; if (m_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", m_ovf); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", m_ovf); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", m_valid); end
        // Clear wins over an accepted bit in the same cycle.
        for (int i = 7; i >= 5; i--) begin
            @(negedge clk);
            din       = part[i];
            din_valid = 1'b1;
        end
        @(negedge clk);
        clr = 1'b1;
        din = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        din_valid = 1'b0;
        n_cmp++; if (m_cnt !== 4'd0) begin n_err++; $display("FAIL clr_priority_cnt: got %0d want 0", m_cnt); end
        send_word(8'h81);
        @(negedge clk);
        din_valid = 1'b0;
        n_cmp++; if (m_dout !== 8'h81) begin n_err++; $display("FAIL clr_no_residue: got %h want 81", m_dout); end
    endtask

    task automatic test_reset_mid_word();
        // Held word 81 is still FULL here; add 5 more bits, then reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din       = 1'b1;
            din_valid = 1'b1;
        end
        @(negedge clk);
        din_valid = 1'b0;
        n_cmp++; if (m_cnt !== 4'd5) begin n_err++; $display("FAIL pre_reset_cnt: got %0d want 5", m_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_dout !== 8'h00) begin n_err++; $display("FAIL async_rst_dout: got %h want 00", m_dout); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_cnt !== 4'd0) begin n_err++; $display("FAIL async_rst_cnt: got %0d want 0", m_cnt); end
        n_cmp++; if (m_state !== EMPTY) begin n_err++; $display("FAIL async_rst_state: got %0d want EMPTY", m_state); end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hC3);
        @(negedge clk);
        din_valid = 1'b0;
        n_cmp++; if (m_dout !== 8'hC3 || m_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_msb: got dout=%h valid=%b want c3/1", m_dout, m_valid); end
        n_cmp++; if (l_dout !== 8'hC3) begin n_err++; $display("FAIL post_rst_lsb: got %h want c3", l_dout); end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    task automatic test_gapped_valid();
        logic [7:0] w;
        w          = 8'h96;
        dout_ready = 1'b0;
        @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            din       = w[i];
            din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            din       = ~w[i];
            n_cmp++;
            if (m_cnt !== 4'((8 - i) % 8)) begin
                n_err++; $display("FAIL gap_cnt_bit%0d: got %0d want %0d", 7 - i, m_cnt, (8 - i) % 8);
            end
            @(negedge clk);
            n_cmp++;
            if (m_cnt !== 4'((8 - i) % 8)) begin
                n_err++; $display("FAIL gap_hold_bit%0d: got %0d want %0d", 7 - i, m_cnt, (8 - i) % 8);
            end
        end
        n_cmp++; if (m_dout !== 8'h96) begin n_err++; $display("FAIL gap_dout: got %h want 96", m_dout); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid: got %b want 1", m_valid); end
    endtask

    // Test sequence and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_msb_lsb_first();
        test_back_to_back();
        test_overflow_clr();
        test_reset_mid_word();
        test_gapped_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
